fifo_pop_ctrl: RTL and testbench

//  Downstream drain stage of the FIFO. Pops words from the FIFO read port and

---
 rtl/fifo_pkg.sv | 15 +
 rtl/skid_buf2.sv | 77 +++++++
 rtl/fifo_pop_ctrl.sv | 72 +++++++
 tb/tb_fifo_pop_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain path: skid state encoding,
// skid depth and the default data width.
package fifo_pkg;

   localparam int SKID_DEPTH    = 2;
   localparam int DEF_BITNUMBER = 8;

   // Skid occupancy doubles as the FSM state.
   typedef enum logic [1:0] {
      S0 = 2'd0,   // empty
      S1 = 2'd1,   // one word (head only)
      S2 = 2'd2    // two words (head + tail)
   } skid_state_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry register skid buffer. The head register drives the output
// directly; the tail register only fills when a word arrives while the
// head is held by the consumer.
module skid_buf2
   import fifo_pkg::*;
#(
   parameter int W = DEF_BITNUMBER
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic [1:0]   occ_o
);

   skid_state_t  state_q, state_d;
   logic [W-1:0] head_q, head_d;
   logic [W-1:0] tail_q, tail_d;

   // State and storage registers; reset empties the buffer and clears the head.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   // Next state: a pop always advances the head, a push lands in the first free slot.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         S0: begin
            if (push_i) begin
               head_d  = din_i;
               state_d = S1;
            end
         end
         S1: begin
            if (push_i && !pop_i) begin
               tail_d  = din_i;
               state_d = S2;
            end else if (!push_i && pop_i) begin
               state_d = S0;
            end else if (push_i && pop_i) begin
               // old head leaves, arriving word becomes the new head
               head_d = din_i;
            end
         end
         S2: begin
            if (pop_i) begin
               head_d = tail_q;
               if (push_i) tail_d  = din_i;
               else        state_d = S1;
            end
         end
         default: state_d = S0;
      endcase
   end

   assign head_o = head_q;
   assign occ_o  = (state_q == S2) ? 2'd2 :
                   (state_q == S1) ? 2'd1 : 2'd0;

   // The pop controller must never deliver a word into a full buffer.
   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !((state_q == S2) && push_i && !pop_i));

endmodule

// File: rtl/fifo_pop_ctrl.sv
// Drain stage behind the FIFO read port. Issues pops, tracks the word in
// flight through the FIFO's one-cycle read latency and presents data on a
// valid/ready interface via a 2-entry skid buffer.
// Optional macro FIFO_POP_STATS_EN enables the delivered-word counter.
module fifo_pop_ctrl
   import fifo_pkg::*;
#(
   parameter int BITNUMBER  = DEF_BITNUMBER,
   parameter int SKID_DEPTH = fifo_pkg::SKID_DEPTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 Fifo_empty,
   input  logic [BITNUMBER-1:0] Fifo_Data_out,
   output logic                 Fifo_rd,
   input  logic                 drain_en,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [BITNUMBER-1:0] out_data,
   output logic                 busy,
   output logic [15:0]          word_count
);

   logic       pending_q;
   logic [1:0] occ;
   logic       pop;
   logic [2:0] fill_c;
   logic [2:0] lim_c;

   assign out_valid = (occ != 2'd0);
   assign pop       = out_valid & out_ready;

   // Words held or arriving next edge must stay below 2 after this cycle's pop.
   assign fill_c  = {1'b0, occ} + {2'b00, pending_q};
   assign lim_c   = 3'd2 + {2'b00, pop};
   assign Fifo_rd = ~reset & drain_en & ~Fifo_empty & (fill_c < lim_c);

   assign busy = pending_q | out_valid;

   // Tracks a pop issued last cycle whose data is on Fifo_Data_out now.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pending_q <= 1'b0;
      else       pending_q <= Fifo_rd;
   end

   skid_buf2 #(.W(BITNUMBER)) u_skid (
      .clk    (clk),
      .reset  (reset),
      .push_i (pending_q),
      .din_i  (Fifo_Data_out),
      .pop_i  (pop),
      .head_o (out_data),
      .occ_o  (occ)
   );

`ifdef FIFO_POP_STATS_EN
   logic [15:0] cnt_q, cnt_d;

   assign cnt_d = cnt_q + {15'd0, pop};

   // Delivered-word counter, wraps naturally at 16 bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= 16'h0;
      else       cnt_q <= cnt_d;
   end

   assign word_count = cnt_q;
`else
   assign word_count = 16'h0;
`endif

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Bench for fifo_pop_ctrl: the FIFO is modelled as a queue, the skid as a
// queue of words plus an in-flight flag; every cycle the DUT outputs are
// compared against that model.
module tb_fifo_pop_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        Fifo_empty;
   logic [7:0]  Fifo_Data_out;
   logic        Fifo_rd;
   logic        drain_en;
   logic        out_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        busy;
   logic [15:0] word_count;

   int checks = 0;
   int errors = 0;

   logic [7:0] fifo_m[$];   // FIFO contents
   logic [7:0] skid_m[$];   // words the stage holds, head first
   int         pend_m;      // a read was issued last cycle
   int         cnt_m;       // delivered words, 16-bit wrap
   int         npops;       // delivered words seen by the bench
   int         nrd;         // pops issued to the FIFO
   logic [7:0] last_pop;

   fifo_pop_ctrl #(.BITNUMBER(8), .SKID_DEPTH(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .Fifo_empty    (Fifo_empty),
      .Fifo_Data_out (Fifo_Data_out),
      .Fifo_rd       (Fifo_rd),
      .drain_en      (drain_en),
      .out_ready     (out_ready),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .busy          (busy),
      .word_count    (word_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int exp_cnt();
`ifdef FIFO_POP_STATS_EN
      return cnt_m;
`else
      return 0;
`endif
   endfunction

   // One clock cycle: check outputs against the model, clock, update model/FIFO.
   task automatic step();
      int   pop_m, exp_rd, occ;
      logic rd_obs;
      Fifo_empty = (fifo_m.size() == 0);
      #1;
      occ    = skid_m.size();
      pop_m  = (occ != 0 && out_ready) ? 1 : 0;
      exp_rd = (drain_en && fifo_m.size() != 0 && (occ + pend_m - pop_m < 2)) ? 1 : 0;
      chk("rd", 32'(Fifo_rd), 32'(exp_rd));
      chk("valid", 32'(out_valid), 32'(occ != 0));
      if (occ != 0) chk("data", 32'(out_data), 32'(skid_m[0]));
      chk("busy", 32'(busy), 32'(pend_m != 0 || occ != 0));
      chk("wcnt", 32'(word_count), 32'(exp_cnt()));
      if (Fifo_empty) chk("rd_on_empty", 32'(Fifo_rd), 32'd0);
      rd_obs = Fifo_rd;
      @(posedge clk);
      #1;
      if (pop_m != 0) begin
         last_pop = skid_m.pop_front();
         cnt_m    = (cnt_m + 1) & 16'hFFFF;
         npops++;
      end
      if (pend_m != 0) skid_m.push_back(Fifo_Data_out);
      pend_m = rd_obs ? 1 : 0;
      if (rd_obs) begin
         nrd++;
         if (fifo_m.size() != 0) Fifo_Data_out = fifo_m.pop_front();
      end else begin
         Fifo_Data_out = 8'($urandom);
      end
   endtask

   task automatic model_reset();
      skid_m.delete();
      pend_m = 0;
      cnt_m  = 0;
   endtask

   // Empty the stage without issuing further reads, then drop FIFO leftovers.
   task automatic flush();
      drain_en  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      fifo_m.delete();
   endtask

   initial begin
      int lat, base, first_seen;
      logic [7:0] exp_next;

      reset = 1'b1; Fifo_empty = 1'b1; Fifo_Data_out = '0;
      drain_en = 1'b0; out_ready = 1'b0;
      model_reset();
      npops = 0; nrd = 0; last_pop = '0;

      // 1: reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rd", 32'(Fifo_rd), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wcnt", 32'(word_count), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // 2: A,B,C streamed, first valid two cycles after the FIFO fills
      fifo_m = '{8'hA1, 8'hB2, 8'hC3};
      drain_en = 1'b1; out_ready = 1'b1;
      lat = -1;
      base = npops;
      for (int i = 0; i < 7; i++) begin
         if (out_valid && lat < 0) lat = i;
         step();
      end
      chk("lat_first_valid", 32'(lat), 32'd2);
      chk("abc_count", 32'(npops - base), 32'd3);
      chk("abc_last", 32'(last_pop), 32'hC3);
      flush();

      // 3: stall with 1..8 queued, then release
      for (int i = 1; i <= 8; i++) fifo_m.push_back(8'(i));
      drain_en = 1'b1; out_ready = 1'b0;
      base = nrd;
      for (int i = 0; i < 6; i++) step();
      chk("stall_pops", 32'(nrd - base), 32'd2);
      chk("stall_head", 32'(out_data), 32'd1);
      chk("stall_valid", 32'(out_valid), 32'd1);
      base = npops;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) step();
      chk("drain8_count", 32'(npops - base), 32'd8);
      chk("drain8_last", 32'(last_pop), 32'd8);
      flush();

      // 4: out_ready toggling every cycle over 2,3,4
      fifo_m = '{8'd2, 8'd3, 8'd4};
      drain_en = 1'b1;
      base = npops;
      for (int i = 0; i < 12; i++) begin
         out_ready = i[0];
         step();
      end
      chk("toggle_count", 32'(npops - base), 32'd3);
      chk("toggle_last", 32'(last_pop), 32'd4);
      flush();

      // 5: drain_en drops right after a pop; in-flight word still lands
      fifo_m = '{8'h55, 8'h66, 8'h77};
      drain_en = 1'b1; out_ready = 1'b0;
      base = nrd;
      step();
      drain_en = 1'b0;
      step();
      chk("inflight_valid", 32'(out_valid), 32'd1);
      chk("inflight_data", 32'(out_data), 32'h55);
      for (int i = 0; i < 4; i++) step();
      chk("no_more_rd", 32'(nrd - base), 32'd1);
      flush();

      // 6: reset mid-stream with a read in flight
      for (int i = 0; i < 20; i++) fifo_m.push_back(8'(8'h10 + i));
      drain_en = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk("pend_before_rst", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_rd", 32'(Fifo_rd), 32'd0);
      chk("midrst_wcnt", 32'(word_count), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      Fifo_Data_out = 8'($urandom);
      exp_next = fifo_m[0];
      base = npops;
      first_seen = 0;
      for (int i = 0; i < 40 && (npops - base) < 9; i++) begin
         step();
         if (first_seen == 0 && npops != base) begin
            first_seen = 1;
            chk("post_rst_word", 32'(last_pop), 32'(exp_next));
         end
      end
      chk("post_rst_pops", 32'(npops - base), 32'd9);
`ifdef FIFO_POP_STATS_EN
      chk("wcnt9", 32'(word_count), 32'd9);
`else
      chk("wcnt9", 32'(word_count), 32'd0);
`endif
      flush();

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         if (fifo_m.size() < 8 && $urandom_range(0, 1) == 1)
            fifo_m.push_back(8'($urandom));
         drain_en  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
